// File: rtl/adbg_or1k_run_ctrl_pkg.sv
// rtl/adbg_or1k_run_ctrl_pkg.sv - shared types for the OR1K run/halt controller
package adbg_or1k_run_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HALT   = 2'b00,
    OP_RESUME = 2'b01,
    OP_STEP   = 2'b10,
    OP_RSVD   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_HALT = 2'b01,
    ST_STEP_RUN  = 2'b10,
    ST_WAIT_RUN  = 2'b11
  } run_state_e;

endpackage

// File: rtl/adbg_or1k_run_timeout.sv
// rtl/adbg_or1k_run_timeout.sv - saturating acknowledge-wait counter
module adbg_or1k_run_timeout #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic cpu_clk_i,
  input  logic cpu_rstn_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(ACK_TIMEOUT));

  // Holds at ACK_TIMEOUT so it can never wrap back under the limit.
  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/adbg_or1k_run_ctrl.sv
// rtl/adbg_or1k_run_ctrl.sv - multi-core halt/resume/step controller with breakpoint cross-trigger
module adbg_or1k_run_ctrl
  import adbg_or1k_run_ctrl_pkg::*;
#(
  parameter int NB_CORES    = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int STEP_CYCLES = 1
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rstn_i,
  input  logic [NB_CORES-1:0] bp_i,
  input  logic [NB_CORES-1:0] halted_i,
  input  logic [NB_CORES-1:0] group_mask_i,
  input  logic                cmd_valid_i,
  input  logic [1:0]          cmd_op_i,
  input  logic [NB_CORES-1:0] cmd_mask_i,
  output logic                cmd_ready_o,
  output logic                cmd_done_o,
  output logic                cmd_err_o,
  output logic [NB_CORES-1:0] cpu_stall_o,
  output logic [NB_CORES-1:0] bp_cause_o
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  run_state_e          state_q;
  logic [NB_CORES-1:0] mask_q;
  logic [NB_CORES-1:0] stall_q;
  logic [NB_CORES-1:0] cause_q;
  logic [SW-1:0]       step_cnt_q;
  logic                done_q;
  logic                err_q;

  logic [NB_CORES-1:0] bp_set;
  logic [NB_CORES-1:0] stall_rel;
  logic [NB_CORES-1:0] stall_hold;
  logic [NB_CORES-1:0] cause_clr;
  logic                step_last;
  logic                waiting;
  logic                expired;

  assign step_last   = (step_cnt_q == SW'(STEP_CYCLES - 1));
  assign waiting     = (state_q == ST_WAIT_HALT) || (state_q == ST_WAIT_RUN);
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign cmd_done_o  = done_q;
  assign cmd_err_o   = err_q;
  assign cpu_stall_o = bp_i | stall_q;
  assign bp_cause_o  = cause_q;

  // A breakpoint in any group member stalls the whole group.
  always_comb begin
    bp_set = bp_i;
    if (|(bp_i & group_mask_i)) bp_set = bp_i | group_mask_i;
  end

  always_comb begin
    stall_rel  = '0;
    stall_hold = '0;
    cause_clr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_op_e'(cmd_op_i))
            OP_HALT:   stall_hold = cmd_mask_i;
            OP_RESUME: begin
              stall_rel = cmd_mask_i;
              cause_clr = cmd_mask_i;
            end
            OP_STEP:   stall_rel = cmd_mask_i;
            default:   ;
          endcase
        end
      end
      ST_STEP_RUN: if (step_last) stall_hold = mask_q;
      default: ;
    endcase
  end

  // bp_set is applied last so a breakpoint beats a simultaneous release.
  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      stall_q <= '0;
      cause_q <= '0;
    end else begin
      stall_q <= (stall_q & ~stall_rel) | stall_hold | bp_set;
      cause_q <= (cause_q & ~cause_clr) | bp_set;
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      step_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            mask_q     <= cmd_mask_i;
            step_cnt_q <= '0;
            if (cmd_op_e'(cmd_op_i) == OP_RSVD) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (cmd_mask_i == '0) begin
              done_q <= 1'b1;
            end else begin
              case (cmd_op_e'(cmd_op_i))
                OP_HALT:   state_q <= ST_WAIT_HALT;
                OP_RESUME: state_q <= ST_WAIT_RUN;
                default:   state_q <= ST_STEP_RUN;
              endcase
            end
          end
        end
        ST_STEP_RUN: begin
          if (step_last) state_q <= ST_WAIT_HALT;
          else           step_cnt_q <= step_cnt_q + SW'(1);
        end
        ST_WAIT_HALT: begin
          if ((halted_i & mask_q) == mask_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else if (expired) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        ST_WAIT_RUN: begin
          if ((halted_i & mask_q & ~cause_q) == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else if (expired) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  adbg_or1k_run_timeout #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timeout (
    .cpu_clk_i (cpu_clk_i),
    .cpu_rstn_i(cpu_rstn_i),
    .clear     (!waiting),
    .enable    (waiting),
    .expired   (expired)
  );

endmodule

// File: tb/tb_adbg_or1k_run_ctrl.sv
// tb/tb_adbg_or1k_run_ctrl.sv - directed self-checking bench for adbg_or1k_run_ctrl
module tb_adbg_or1k_run_ctrl;

  localparam int NB  = 4;
  localparam int ACK = 255;

  typedef struct {
    string tag;
    logic  err;
    int    lat;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] bp_i;
  logic [NB-1:0] halted_i;
  logic [NB-1:0] group_mask_i;
  logic          cmd_valid_i;
  logic [1:0]    cmd_op_i;
  logic [NB-1:0] cmd_mask_i;
  logic          cmd_ready_o;
  logic          cmd_done_o;
  logic          cmd_err_o;
  logic [NB-1:0] cpu_stall_o;
  logic [NB-1:0] bp_cause_o;

  int   n_chk;
  int   n_fail;
  int   cyc;
  int   acc_cyc;
  exp_t sb[$];

  adbg_or1k_run_ctrl #(
    .NB_CORES(NB), .ACK_TIMEOUT(ACK), .STEP_CYCLES(1)
  ) dut (
    .cpu_clk_i   (clk),
    .cpu_rstn_i  (rst_n),
    .bp_i        (bp_i),
    .halted_i    (halted_i),
    .group_mask_i(group_mask_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_op_i    (cmd_op_i),
    .cmd_mask_i  (cmd_mask_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_done_o  (cmd_done_o),
    .cmd_err_o   (cmd_err_o),
    .cpu_stall_o (cpu_stall_o),
    .bp_cause_o  (bp_cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    cyc++;
  endtask

  // Drive a command for one cycle, then scramble the inputs to prove capture.
  task automatic issue(input logic [1:0] op, input logic [NB-1:0] mask);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_mask_i  = mask;
    #1 chk("ready_at_issue", cmd_ready_o, 1);
    nxt();
    cmd_valid_i = 1'b0;
    cmd_op_i    = ~op;
    cmd_mask_i  = ~mask;
    acc_cyc     = cyc;
  endtask

  task automatic expect_done(input string tag, input logic err, input int lat);
    exp_t e;
    e.tag = tag;
    e.err = err;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    exp_t e;
    bit   seen;
    seen  = 1'b0;
    e.tag = "none";
    e.err = 1'b0;
    e.lat = 0;
    if (sb.size() > 0) e = sb.pop_front();
    for (int i = 0; i < 400; i++) begin
      if (cmd_done_o) begin
        seen = 1'b1;
        break;
      end
      nxt();
    end
    chk({e.tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({e.tag, "_latency"}, cyc - acc_cyc, e.lat);
      chk({e.tag, "_err"}, cmd_err_o, e.err);
      nxt();
      chk({e.tag, "_done_pulse"}, cmd_done_o, 0);
      chk({e.tag, "_err_pulse"}, cmd_err_o, 0);
      chk({e.tag, "_ready_after"}, cmd_ready_o, 1);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; acc_cyc = 0;
    rst_n = 1'b0; bp_i = 4'b0010; halted_i = '0; group_mask_i = '0;
    cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_mask_i = '0;
    nxt(); nxt();
    chk("rst_stall_eq_bp", cpu_stall_o, 4'b0010);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_done", cmd_done_o, 0);
    chk("rst_err", cmd_err_o, 0);
    chk("rst_cause", bp_cause_o, 4'b0000);
    bp_i = '0;
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("post_rst_stall", cpu_stall_o, 4'b0000);

    // HALT 0101, halted rises three cycles after acceptance
    expect_done("halt0101", 1'b0, 4);
    issue(2'b00, 4'b0101);
    chk("halt_stall", cpu_stall_o, 4'b0101);
    chk("halt_busy", cmd_ready_o, 0);
    nxt(); nxt(); nxt();
    halted_i = 4'b0101;
    wait_done();
    chk("halt_cause", bp_cause_o, 4'b0000);

    // RESUME 0101, finishes once cores report running
    expect_done("resume0101", 1'b0, 3);
    issue(2'b01, 4'b0101);
    chk("resume_stall", cpu_stall_o, 4'b0000);
    nxt(); nxt();
    halted_i = '0;
    wait_done();

    // breakpoint pulse on core 1 cross-triggers group 0011
    bp_i = 4'b0010; group_mask_i = 4'b0011;
    #1 chk("bp_same_cycle", cpu_stall_o, 4'b0010);
    nxt();
    bp_i = '0;
    #1 chk("bp_group_stall", cpu_stall_o, 4'b0011);
    chk("bp_group_cause", bp_cause_o, 4'b0011);

    // RESUME 0011 from halted clears stall and cause
    halted_i = 4'b0011;
    expect_done("resume0011", 1'b0, 3);
    issue(2'b01, 4'b0011);
    chk("resume2_stall", cpu_stall_o, 4'b0000);
    chk("resume2_cause", bp_cause_o, 4'b0000);
    nxt(); nxt();
    halted_i = '0;
    wait_done();

    // STEP core 0: halt it first, then release for one cycle
    halted_i = 4'b0001;
    expect_done("halt0001", 1'b0, 1);
    issue(2'b00, 4'b0001);
    wait_done();
    expect_done("step0001", 1'b0, 3);
    issue(2'b10, 4'b0001);
    chk("step_released", cpu_stall_o, 4'b0000);
    halted_i = '0;
    nxt();
    chk("step_restall", cpu_stall_o, 4'b0001);
    nxt();
    chk("step_held", cpu_stall_o, 4'b0001);
    halted_i = 4'b0001;
    wait_done();

    // reserved op errors out, no state change
    expect_done("reserved", 1'b1, 0);
    issue(2'b11, 4'b1111);
    wait_done();
    chk("reserved_stall", cpu_stall_o, 4'b0001);

    // empty mask completes immediately without error
    expect_done("zero_mask", 1'b0, 0);
    issue(2'b00, 4'b0000);
    wait_done();

    // mask captured at acceptance, later input changes ignored
    expect_done("capture", 1'b0, 2);
    issue(2'b00, 4'b0100);
    chk("capture_stall", cpu_stall_o, 4'b0101);
    nxt();
    halted_i = 4'b0100;
    wait_done();
    chk("capture_stall_after", cpu_stall_o, 4'b0101);

    // breakpoint coincident with RESUME release wins
    halted_i = '0; group_mask_i = '0;
    bp_i = 4'b0100;
    expect_done("bp_vs_resume", 1'b0, 1);
    issue(2'b01, 4'b0101);
    bp_i = '0;
    #1 chk("bp_wins_stall", cpu_stall_o, 4'b0100);
    chk("bp_wins_cause", bp_cause_o, 4'b0100);
    wait_done();

    // HALT core 3 never acknowledges: timeout with error, stall kept
    expect_done("timeout", 1'b1, ACK + 1);
    issue(2'b00, 4'b1000);
    wait_done();
    chk("timeout_stall", cpu_stall_o, 4'b1100);

    // reset in WAIT_HALT aborts silently
    issue(2'b00, 4'b0010);
    nxt(); nxt();
    bp_i  = 4'b0001;
    rst_n = 1'b0;
    #1 chk("abort_stall", cpu_stall_o, 4'b0001);
    chk("abort_ready", cmd_ready_o, 1);
    chk("abort_done", cmd_done_o, 0);
    chk("abort_err", cmd_err_o, 0);
    chk("abort_cause", bp_cause_o, 4'b0000);
    nxt(); nxt();
    chk("abort_done_held", cmd_done_o, 0);
    bp_i = '0;
    rst_n = 1'b1;
    nxt();
    chk("abort_post_stall", cpu_stall_o, 4'b0000);
    chk("abort_post_done", cmd_done_o, 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adbg_or1k_run_ctrl.md
ADBG_OR1K_RUN_CTRL -- requirements
Module: adbg_or1k_run_ctrl

Interface
REQ-001 Parameter NB_CORES, default 4, number of controlled cores.
REQ-002 Parameter ACK_TIMEOUT, default 255, maximum cycles to wait for core acknowledge.
REQ-003 Parameter STEP_CYCLES, default 1, cycles stall is released during a STEP.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 cpu_clk_i  in  1  sole clock; all state rising-edge.
REQ-006 cpu_rstn_i  in  1  asynchronous active-low reset.
REQ-007 bp_i  in  NB_CORES  per-core breakpoint, level or pulse.
REQ-008 halted_i  in  NB_CORES  per-core acknowledge: pipeline drained, core stalled.
REQ-009 group_mask_i  in  NB_CORES  cross-trigger group membership.
REQ-010 cmd_valid_i  in  1  host command request.
REQ-011 cmd_op_i  in  2  00 HALT, 01 RESUME, 10 STEP, 11 reserved.
REQ-012 cmd_mask_i  in  NB_CORES  target cores of command.
REQ-013 cmd_ready_o  out  1  command accepted when valid and ready both high.
REQ-014 cmd_done_o  out  1  one-cycle pulse at command completion.
REQ-015 cmd_err_o  out  1  one-cycle pulse coincident with cmd_done_o on timeout or reserved op.
REQ-016 cpu_stall_o  out  NB_CORES  per-core stall request.
REQ-017 bp_cause_o  out  NB_CORES  sticky: core stalled by breakpoint or cross-trigger.

Function
REQ-018 cpu_stall_o SHALL equal bp_i OR stall_q (registered), so a breakpoint stalls its core in the same cycle.
REQ-019 bp_i[i] high SHALL set stall_q[i] and bp_cause_o[i] at the next edge.
REQ-020 bp_i[i] high with group_mask_i[i] high SHALL set stall_q and bp_cause_o for every core with group_mask_i set, next edge.
REQ-021 FSM states: IDLE, WAIT_HALT, STEP_RUN, WAIT_RUN; cmd_ready_o high only in IDLE.
REQ-022 Command fields SHALL be captured at acceptance; later input changes have no effect.
REQ-023 HALT: stall_q |= mask at acceptance edge; go WAIT_HALT.
REQ-024 WAIT_HALT completes when (halted_i AND mask) == mask; then cmd_done_o pulses next cycle, return IDLE.
REQ-025 RESUME: stall_q &= ~mask and bp_cause_o &= ~mask at acceptance edge; go WAIT_RUN.
REQ-026 WAIT_RUN completes when (halted_i AND mask AND ~bp_cause_o) == 0; done pulse, return IDLE.
REQ-027 STEP: stall_q &= ~mask for exactly STEP_CYCLES cycles in STEP_RUN, then stall_q |= mask, go WAIT_HALT.
REQ-028 Timeout counter SHALL clear on entry to WAIT_HALT/WAIT_RUN, increment each waiting cycle; reaching ACK_TIMEOUT forces IDLE with cmd_done_o and cmd_err_o; stall_q untouched.
REQ-029 Mask all-zero SHALL be accepted and complete with cmd_done_o the cycle after acceptance, no error.
REQ-030 Reserved op SHALL complete next cycle with cmd_done_o and cmd_err_o, no state change.
REQ-031 Simultaneous bp_i[i] and RESUME/STEP release of core i: breakpoint wins, stall_q[i] and bp_cause_o[i] set.
REQ-032 Breakpoint during WAIT_RUN or STEP_RUN on a targeted core SHALL not block completion (REQ-026 exclusion).
REQ-033 Counter width SHALL be clog2(ACK_TIMEOUT+1); no wrap before timeout.

Reset
REQ-034 Asserting cpu_rstn_i at any time SHALL abort any command: state IDLE, stall_q 0, bp_cause_o 0, counter 0.
REQ-035 During reset: cmd_ready_o 1, cmd_done_o 0, cmd_err_o 0, cpu_stall_o = bp_i.

Structure
REQ-036 Package adbg_or1k_run_ctrl_pkg SHALL hold the command-op enum and FSM state enum.
REQ-037 Timeout counter SHALL be sub-module adbg_or1k_run_timeout (clear, enable, expired).

Verification
REQ-038 HALT mask 0101, halted_i rises 3 cycles later -> cpu_stall_o 0101 after accept edge, cmd_done_o 1 cycle, no err.
REQ-039 bp_i[1] 1-cycle pulse, group_mask_i 0011 -> cpu_stall_o[1] same cycle, then stall 0011, bp_cause_o 0011.
REQ-040 RESUME mask 0011 from halted -> cpu_stall_o 0000, bp_cause_o 0000, done when halted_i drops.
REQ-041 STEP mask 0001, STEP_CYCLES 1 -> cpu_stall_o[0] low exactly 1 cycle, then high, done on halted_i[0].
REQ-042 HALT mask 1000, halted_i held 0 -> done+err at ACK_TIMEOUT cycles, cpu_stall_o[3] stays 1.
REQ-043 Reset asserted in WAIT_HALT -> all outputs per REQ-035 immediately, no done pulse.
